// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared slot record, FSM states and stage indices for the hazard scoreboard
package hazard_scoreboard_pkg;

    // Widest register address a slot can hold; narrower addresses are zero-extended.
    localparam int SLOT_ADDR_W = 8;
    localparam int MEM_SLOT    = 1;

    typedef struct packed {
        logic                   valid;
        logic                   wb_en;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic [SLOT_ADDR_W-1:0] dest;
    } slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and stall/freeze response bundle
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int CNT_W      = 16
);
    logic                          id_valid_in;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_in;
    logic [NUM_SRC-1:0]            id_src_used_in;
    logic                          id_wb_en_in;
    logic                          id_mem_r_en_in;
    logic                          id_mem_w_en_in;
    logic [REG_ADDR_W-1:0]         id_dest_in;
    logic                          use_forwarding_in;
    logic                          sram_ready_in;
    logic                          flush_in;
    logic                          cnt_clr_in;
    logic                          hazard_out;
    logic                          freeze_out;
    logic [CNT_W-1:0]              stall_cnt_out;
    logic [1:0]                    state_out;

    modport master (
        output id_valid_in, id_src_in, id_src_used_in, id_wb_en_in, id_mem_r_en_in,
               id_mem_w_en_in, id_dest_in, use_forwarding_in, sram_ready_in, flush_in, cnt_clr_in,
        input  hazard_out, freeze_out, stall_cnt_out, state_out
    );

    modport slave (
        input  id_valid_in, id_src_in, id_src_used_in, id_wb_en_in, id_mem_r_en_in,
               id_mem_w_en_in, id_dest_in, use_forwarding_in, sram_ready_in, flush_in, cnt_clr_in,
        output hazard_out, freeze_out, stall_cnt_out, state_out
    );
endinterface

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - flags when one in-flight slot writes any register the ID instruction reads
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3
) (
    input  slot_t                         i_slot,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src,
    input  logic [NUM_SRC-1:0]            i_src_used,
    output logic                          o_match
);

    logic w_any_src;

    always_comb begin
        w_any_src = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_src_used[i] && (i_slot.dest == SLOT_ADDR_W'(i_src[i*REG_ADDR_W +: REG_ADDR_W]))) begin
                w_any_src = 1'b1;
            end
        end
    end

    assign o_match = i_slot.valid & i_slot.wb_en & w_any_src;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tracks in-flight writers, raises ID stalls and MEM-wait freezes, counts stall cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            r_slots [DEPTH];
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DEPTH-1:0] w_match;
    logic             w_mode_term;
    logic             w_hazard;
    logic             w_freeze;
    slot_t            w_id_slot;

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        hazard_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_SRC    (NUM_SRC)
        ) u_match (
            .i_slot     (r_slots[k]),
            .i_src      (bus.id_src_in),
            .i_src_used (bus.id_src_used_in),
            .o_match    (w_match[k])
        );
    end

    // With forwarding only a load still in EXE cannot supply its result in time.
    assign w_mode_term = bus.use_forwarding_in ? (w_match[0] & r_slots[0].mem_r_en) : (|w_match);
    assign w_hazard    = bus.id_valid_in & w_mode_term & ~bus.flush_in;
    assign w_freeze    = r_slots[MEM_SLOT].valid
                       & (r_slots[MEM_SLOT].mem_r_en | r_slots[MEM_SLOT].mem_w_en)
                       & ~bus.sram_ready_in;

    always_comb begin
        w_id_slot = '0;
        if (bus.id_valid_in && !w_hazard && !bus.flush_in) begin
            w_id_slot.valid    = 1'b1;
            w_id_slot.wb_en    = bus.id_wb_en_in;
            w_id_slot.mem_r_en = bus.id_mem_r_en_in;
            w_id_slot.mem_w_en = bus.id_mem_w_en_in;
            w_id_slot.dest     = SLOT_ADDR_W'(bus.id_dest_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slots[k] <= '0;
            end
        end else if (!w_freeze) begin
            r_slots[0] <= w_id_slot;
            for (int k = 1; k < DEPTH; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = RUN;
        if (w_freeze) begin
            w_state_nxt = MEM_WAIT;
        end else if (w_hazard) begin
            w_state_nxt = STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr_in) begin
            r_cnt <= '0;
        end else if ((w_hazard || w_freeze) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.hazard_out    = w_hazard;
    assign bus.freeze_out    = w_freeze;
    assign bus.stall_cnt_out = r_cnt;
    assign bus.state_out     = r_state;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a slot-list model
module tb_hazard_scoreboard;

    localparam int AW    = 4;
    localparam int NS    = 3;
    localparam int DEPTH = 2;
    localparam int CW    = 3;
    localparam int CMAX  = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(AW), .NUM_SRC(NS), .CNT_W(CW)) bif ();

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .NUM_SRC    (NS),
        .DEPTH      (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model: list of in-flight instructions, index 0 = EXE.
    int m_v [DEPTH];
    int m_wb[DEPTH];
    int m_mr[DEPTH];
    int m_mw[DEPTH];
    int m_d [DEPTH];
    int m_state;
    int m_cnt;
    logic [31:0] o_h;
    logic [31:0] o_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic bit reads_reg(input int r);
        logic [NS*AW-1:0] srcs;
        srcs = bif.id_src_in;
        for (int i = 0; i < NS; i++) begin
            if (bif.id_src_used_in[i] && (int'(srcs[i*AW +: AW]) == r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_hazard();
        if (!bif.id_valid_in || bif.flush_in) return 0;
        if (bif.use_forwarding_in)
            return (m_v[0] != 0 && m_wb[0] != 0 && m_mr[0] != 0 && reads_reg(m_d[0])) ? 1 : 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k] != 0 && m_wb[k] != 0 && reads_reg(m_d[k])) return 1;
        end
        return 0;
    endfunction

    function automatic int exp_freeze();
        return (m_v[1] != 0 && (m_mr[1] != 0 || m_mw[1] != 0) && !bif.sram_ready_in) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 0; m_wb[k] = 0; m_mr[k] = 0; m_mw[k] = 0; m_d[k] = 0;
        end
        m_state = 0;
        m_cnt   = 0;
    endtask

    task automatic set_id(input int v, input int wb, input int mr, input int mw, input int dest,
                          input int s0, input int s1, input int s2, input int used);
        bif.id_valid_in    = v[0];
        bif.id_wb_en_in    = wb[0];
        bif.id_mem_r_en_in = mr[0];
        bif.id_mem_w_en_in = mw[0];
        bif.id_dest_in     = dest[AW-1:0];
        bif.id_src_in      = {s2[AW-1:0], s1[AW-1:0], s0[AW-1:0]};
        bif.id_src_used_in = used[NS-1:0];
    endtask

    // Inputs are already applied one unit after the previous edge.
    task automatic cycle(input string tag);
        int h, f;
        #2;
        h = exp_hazard();
        f = exp_freeze();
        o_h = 32'(bif.hazard_out);
        o_f = 32'(bif.freeze_out);
        check({tag, ".hazard"}, o_h, h);
        check({tag, ".freeze"}, o_f, f);
        check({tag, ".state"}, 32'(bif.state_out), m_state);
        check({tag, ".cnt"}, 32'(bif.stall_cnt_out), m_cnt);
        @(posedge clk);
        m_state = f ? 2 : (h ? 1 : 0);
        if (bif.cnt_clr_in) m_cnt = 0;
        else if ((h || f) && m_cnt < CMAX) m_cnt++;
        if (!f) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_wb[k] = m_wb[k-1]; m_mr[k] = m_mr[k-1];
                m_mw[k] = m_mw[k-1]; m_d[k] = m_d[k-1];
            end
            if (bif.id_valid_in && !h && !bif.flush_in) begin
                m_v[0] = 1; m_wb[0] = bif.id_wb_en_in; m_mr[0] = bif.id_mem_r_en_in;
                m_mw[0] = bif.id_mem_w_en_in; m_d[0] = int'(bif.id_dest_in);
            end else begin
                m_v[0] = 0; m_wb[0] = 0; m_mr[0] = 0; m_mw[0] = 0; m_d[0] = 0;
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bif.use_forwarding_in = 1'b0;
        bif.sram_ready_in     = 1'b1;
        bif.flush_in          = 1'b0;
        bif.cnt_clr_in        = 1'b0;
        #12;
        check("reset.hazard", 32'(bif.hazard_out), 0);
        check("reset.freeze", 32'(bif.freeze_out), 0);
        check("reset.state", 32'(bif.state_out), 0);
        check("reset.cnt", 32'(bif.stall_cnt_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // No forwarding: R3 writer ages through EXE then MEM.
        set_id(1, 1, 0, 0, 3, 0, 0, 0, 0);
        cycle("c1.issue");
        set_id(1, 1, 0, 0, 4, 3, 0, 0, 3'b001);
        cycle("c1.exe");
        check("c1.exe_stall", o_h, 1);
        cycle("c1.mem");
        check("c1.mem_stall", o_h, 1);
        cycle("c1.go");
        check("c1.released", o_h, 0);
        check("c1.cnt2", 32'(bif.stall_cnt_out), 2);

        // Forwarding: only a load in EXE stalls, and only on a real dest match.
        bif.use_forwarding_in = 1'b1;
        bif.cnt_clr_in = 1'b1;
        set_id(1, 1, 1, 0, 5, 0, 0, 0, 0);
        cycle("c2.ldr");
        bif.cnt_clr_in = 1'b0;
        set_id(1, 1, 0, 0, 6, 0, 5, 0, 3'b010);
        cycle("c2.use");
        check("c2.loaduse", o_h, 1);
        cycle("c2.after");
        check("c2.one_stall", o_h, 0);
        set_id(1, 1, 1, 0, 5, 0, 0, 0, 0);
        cycle("c2.ldr2");
        set_id(1, 1, 0, 0, 8, 0, 6, 0, 3'b010);
        cycle("c2.other");
        check("c2.no_stall", o_h, 0);
        check("c2.cnt1", 32'(bif.stall_cnt_out), 1);

        // Load held in MEM while SRAM is busy.
        bif.use_forwarding_in = 1'b0;
        bif.cnt_clr_in = 1'b1;
        set_id(1, 1, 1, 0, 7, 0, 0, 0, 0);
        cycle("c3.ldr");
        bif.cnt_clr_in = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("c3.bubble");
        bif.sram_ready_in = 1'b0;
        set_id(1, 1, 0, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("c3.wait");
            check("c3.frozen", o_f, 1);
            check("c3.memwait", 32'(bif.state_out), 2);
        end
        check("c3.cnt4", 32'(bif.stall_cnt_out), 4);
        bif.sram_ready_in = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("c3.done");
        check("c3.unfrozen", o_f, 0);

        // Flush beats a hazard; the killed instruction must not become a writer.
        set_id(1, 1, 0, 0, 2, 0, 0, 0, 0);
        cycle("c4.w2");
        bif.flush_in = 1'b1;
        set_id(1, 1, 0, 0, 9, 2, 0, 0, 3'b001);
        cycle("c4.flush");
        check("c4.no_hazard", o_h, 0);
        bif.flush_in = 1'b0;
        set_id(1, 0, 0, 0, 1, 9, 0, 0, 3'b001);
        cycle("c4.probe");
        check("c4.bubble", o_h, 0);

        // Saturation of the 3-bit counter, then clear under an active freeze.
        bif.cnt_clr_in = 1'b1;
        set_id(1, 1, 0, 1, 3, 0, 0, 0, 0);
        cycle("c5.str");
        bif.cnt_clr_in = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("c5.bubble");
        bif.sram_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) cycle("c5.wait");
        check("c5.sat", 32'(bif.stall_cnt_out), CMAX);
        bif.cnt_clr_in = 1'b1;
        cycle("c5.clr");
        bif.cnt_clr_in = 1'b0;
        check("c5.cleared", 32'(bif.stall_cnt_out), 0);
        cycle("c5.resume");

        // Reset in the middle of a freeze.
        #2;
        rst_n = 1'b0;
        #1;
        check("c6.hazard", 32'(bif.hazard_out), 0);
        check("c6.freeze", 32'(bif.freeze_out), 0);
        check("c6.state", 32'(bif.state_out), 0);
        check("c6.cnt", 32'(bif.stall_cnt_out), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("c6.post1");
        check("c6.no_freeze", o_f, 0);
        cycle("c6.post2");
        bif.sram_ready_in = 1'b1;

        for (int n = 0; n < 400; n++) begin
            set_id(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)));
            bif.use_forwarding_in = 1'($urandom_range(0, 1));
            bif.flush_in          = ($urandom_range(0, 7) == 0);
            bif.sram_ready_in     = ($urandom_range(0, 3) != 0);
            bif.cnt_clr_in        = ($urandom_range(0, 15) == 0);
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_ADDR_W, default 4: register-address width.
REQ-002 Parameter NUM_SRC, default 3: ID source operands checked (Rn, Rm, Rs).
REQ-003 Parameter DEPTH, default 2, minimum 2: tracked in-flight slots; slot 0 = EXE, slot 1 = MEM, higher = later stages.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 id_valid_in  input  1  ID holds a real instruction.
REQ-008 id_src_in  input  NUM_SRC*REG_ADDR_W  packed source addresses; source i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-009 id_src_used_in  input  NUM_SRC  bit i set: source i is read.
REQ-010 id_wb_en_in, id_mem_r_en_in, id_mem_w_en_in  input  1 each  ID write-back, load and store flags.
REQ-011 id_dest_in  input  REG_ADDR_W  ID destination register.
REQ-012 use_forwarding_in  input  1  forwarding mode select.
REQ-013 sram_ready_in  input  1  SRAM has completed the MEM-stage access.
REQ-014 flush_in  input  1  taken branch; kills the ID instruction.
REQ-015 cnt_clr_in  input  1  synchronous clear of the stall counter.
REQ-016 hazard_out  output  1  stall IF/ID; insert a bubble into EXE.
REQ-017 freeze_out  output  1  hold every pipeline register.
REQ-018 stall_cnt_out  output  CNT_W  cycles with hazard_out or freeze_out high.
REQ-019 state_out  output  2  FSM state: 0 RUN, 1 STALL, 2 MEM_WAIT.

Function
REQ-020 Each slot SHALL hold {valid, wb_en, mem_r_en, mem_w_en, dest}.
REQ-021 Match(k) SHALL be true when slot k is valid, has wb_en set, and its dest equals some source i with id_src_used_in[i] set.
REQ-022 raw_hazard SHALL be id_valid_in AND the mode-dependent term.
REQ-023 Without forwarding, the mode-dependent term SHALL be the OR of Match(k) over all slots.
REQ-024 With forwarding, the mode-dependent term SHALL be Match(0) AND slot 0 mem_r_en (load-use only, dest-qualified).
REQ-025 hazard_out SHALL equal raw_hazard AND NOT flush_in (combinational).
REQ-026 freeze_out SHALL equal slot 1 valid AND (slot 1 mem_r_en OR mem_w_en) AND NOT sram_ready_in (combinational).
REQ-027 Advance is defined as NOT freeze_out; on advance, slot k SHALL take slot k-1 for k = 1..DEPTH-1.
REQ-028 On advance, slot 0 SHALL load the ID fields with valid = id_valid_in AND NOT hazard_out AND NOT flush_in; otherwise slot 0 SHALL load a bubble (all zero).
REQ-029 While freeze_out is high, all slots SHALL hold their value; hazard_out is still computed but has no effect on the slots.
REQ-030 Flush together with hazard: hazard_out SHALL be 0 and slot 0 SHALL receive a bubble.
REQ-031 FSM, registered each cycle: MEM_WAIT if freeze_out, else STALL if hazard_out, else RUN; MEM_WAIT has priority.
REQ-032 Counter: cnt_clr_in SHALL load 0 and takes priority.
REQ-033 Otherwise the counter SHALL increment by 1 in each cycle with hazard_out or freeze_out high, saturating at 2^CNT_W-1 with no wrap.
REQ-034 Latency: hazard_out and freeze_out SHALL respond in the same cycle as their inputs; slots, FSM and counter SHALL update on the next rising edge.

Reset
REQ-035 rst_n low SHALL asynchronously clear all slots to bubbles, set the FSM to RUN and set stall_cnt_out to 0.
REQ-036 During reset, hazard_out and freeze_out SHALL be 0 whenever id_valid_in is 0.
REQ-037 Reset asserted mid-stall or mid-freeze SHALL discard all tracking state, with no residual stall after release.

Structure
REQ-038 A shared package SHALL hold the slot struct typedef, the FSM state enum (RUN, STALL, MEM_WAIT) and the MEM slot index constant 1.
REQ-039 One sub-module, hazard_src_match, SHALL compare one slot against all NUM_SRC sources; it SHALL be instantiated once per slot.

Verification
REQ-040 Case 1: no forwarding, EXE slot dest R3 with wb_en, ID src0 = R3 used -> hazard_out = 1 for 2 cycles (EXE, then MEM), a bubble each cycle, stall_cnt = 2.
REQ-041 Case 2: forwarding, LDR R5 in EXE, ID uses R5 -> exactly 1 stall cycle; ID uses R6 instead -> no stall.
REQ-042 Case 3: load in MEM, sram_ready low for 4 cycles -> freeze_out = 1 for 4 cycles, slots unchanged, state_out = 2 during freeze, stall_cnt = 4.
REQ-043 Case 4: hazard condition with flush_in = 1 -> hazard_out = 0 and slot 0 = bubble on the next edge.
REQ-044 Case 5: CNT_W = 3, 10 stall cycles -> stall_cnt_out saturates at 7; cnt_clr_in -> 0.
REQ-045 Case 6: rst_n pulsed low during freeze -> all outputs 0 and state RUN immediately, no stall after release.
